psr_cond_unit: RTL and testbench

- Consumer end of the ALU flag interface.
- Holds the 5-bit processor status register (PSR), updated from the ALU's PSRwrite output under a per-flag write mask.
- Evaluates 4-bit branch/jump condition codes against the PSR and returns a registered taken/not-taken decision to the fetch/branch logic over a valid/ready handshake.
- Sits between the ALU/writeback stage and the PC-update logic.

---
 rtl/psr_cond_unit_if.sv | 27 ++
 rtl/psr_cond_unit.sv | 101 ++++++++++
 tb/tb_psr_cond_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psr_cond_unit_if.sv
// Flag-update and condition/decision bus between the ALU/writeback stage,
// the PSR condition unit and the PC-update logic.
interface psr_cond_unit_if;
  logic [4:0] PSRwrite;     // ALU flags: [4]=N [3]=Z [2]=F [1]=L [0]=C
  logic [4:0] flag_we;      // per-flag write enable, same bit order
  logic       psr_ld;       // full PSR restore, overrides flag_we
  logic [4:0] psr_ld_data;  // value for psr_ld
  logic       cond_valid;   // condition request valid
  logic [3:0] cond_code;    // condition code
  logic       cond_ready;   // unit can accept a condition
  logic       taken_valid;  // decision available
  logic       taken;        // 1 = condition true
  logic       taken_ready;  // downstream accepts decision
  logic [4:0] psr;          // current PSR contents

  // Producer side: ALU/writeback plus the branch requester and decision sink.
  modport master (
    output PSRwrite, flag_we, psr_ld, psr_ld_data, cond_valid, cond_code, taken_ready,
    input  cond_ready, taken_valid, taken, psr
  );

  // Condition unit side.
  modport slave (
    input  PSRwrite, flag_we, psr_ld, psr_ld_data, cond_valid, cond_code, taken_ready,
    output cond_ready, taken_valid, taken, psr
  );
endinterface

// File: rtl/psr_cond_unit.sv
// PSR condition unit: holds the 5-bit processor status register, applies
// masked flag updates or full restores, and evaluates branch condition codes
// into a single-entry registered taken/not-taken decision with a valid/ready
// handshake toward the fetch/branch logic.
module psr_cond_unit #(
  parameter bit         FORWARD = 1'b1,
  parameter logic [4:0] PSR_RST = 5'b00000
) (
  input logic           clk,
  input logic           reset,  // synchronous, active low
  psr_cond_unit_if.slave bus
);

  localparam int N_BIT = 4;
  localparam int Z_BIT = 3;
  localparam int F_BIT = 2;
  localparam int L_BIT = 1;
  localparam int C_BIT = 0;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7,
    CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB,
    CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF
  } cond_e;

  logic [4:0] psr_q;
  logic [4:0] psr_next;
  logic [4:0] eff;
  logic       taken_valid_q;
  logic       taken_q;
  logic       accept;
  logic       decision;

  // Evaluate one condition code against a flag set.
  function automatic logic eval_cond(input cond_e code, input logic [4:0] f);
    logic r;
    r = 1'b0;
    unique case (code)
      CC_EQ: r =  f[Z_BIT];
      CC_NE: r = !f[Z_BIT];
      CC_CS: r =  f[C_BIT];
      CC_CC: r = !f[C_BIT];
      CC_HI: r =  f[L_BIT];
      CC_LS: r = !f[L_BIT];
      CC_GT: r =  f[N_BIT];
      CC_LE: r = !f[N_BIT];
      CC_FS: r =  f[F_BIT];
      CC_FC: r = !f[F_BIT];
      CC_LO: r = !f[L_BIT] && !f[Z_BIT];
      CC_HS: r =  f[L_BIT] ||  f[Z_BIT];
      CC_LT: r = !f[N_BIT] && !f[Z_BIT];
      CC_GE: r =  f[N_BIT] ||  f[Z_BIT];
      CC_UC: r = 1'b1;
      CC_NV: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next PSR: full restore wins, otherwise merge ALU flags under the write mask.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    psr_next = psr_q;
    if (bus.psr_ld) begin
      psr_next = bus.psr_ld_data;
    end else begin
      psr_next = (psr_q & ~bus.flag_we) | (bus.PSRwrite & bus.flag_we);
    end
  end

  // Flag view seen by a condition accepted this cycle.
  assign eff = FORWARD ? psr_next : psr_q;

  // The output register can take a new decision when empty or draining now.
  assign bus.cond_ready = !taken_valid_q || bus.taken_ready;
  assign accept         = bus.cond_valid && bus.cond_ready;
  assign decision       = eval_cond(cond_e'(bus.cond_code), eff);

  // PSR register and single-entry decision register; reset beats accept and drain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      psr_q         <= PSR_RST;
      taken_valid_q <= 1'b0;
      taken_q       <= 1'b0;
    end else begin
      psr_q <= psr_next;
      if (accept) begin
        taken_valid_q <= 1'b1;
        taken_q       <= decision;
      end else if (bus.taken_ready) begin
        taken_valid_q <= 1'b0;
      end
    end
  end

  assign bus.psr         = psr_q;
  assign bus.taken_valid = taken_valid_q;
  assign bus.taken       = taken_q;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Testbench for psr_cond_unit: a FORWARD=1 and a FORWARD=0 instance share
// the same stimulus; a transaction-level model predicts both every cycle,
// and directed sequences pin the reset, masking, sweep, forwarding,
// backpressure and mid-handshake reset corners to hand-derived values.
module tb_psr_cond_unit;

  logic clk;
  logic reset;

  psr_cond_unit_if bus ();   // drives the FORWARD=1 instance
  psr_cond_unit_if bus0 ();  // mirrors the inputs into the FORWARD=0 instance

  assign bus0.PSRwrite    = bus.PSRwrite;
  assign bus0.flag_we     = bus.flag_we;
  assign bus0.psr_ld      = bus.psr_ld;
  assign bus0.psr_ld_data = bus.psr_ld_data;
  assign bus0.cond_valid  = bus.cond_valid;
  assign bus0.cond_code   = bus.cond_code;
  assign bus0.taken_ready = bus.taken_ready;

  psr_cond_unit #(.FORWARD(1'b1), .PSR_RST(5'b00000)) dut_fwd (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  psr_cond_unit #(.FORWARD(1'b0), .PSR_RST(5'b00000)) dut_nofwd (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model. Index 1 = FORWARD=1 instance, index 0 = FORWARD=0.
  // ---------------------------------------------------------------------
  logic [4:0] m_psr;
  logic [1:0] m_tv;
  logic [1:0] m_tk;
  bit         m_synced = 1'b0;

  // Codes come in complementary pairs: code>>1 picks a predicate,
  // code[0] inverts it (NE=!EQ, HS=!LO, GE=!LT, NV=!UC, ...).
  function automatic logic model_cond(input logic [3:0] code, input logic [4:0] f);
    logic n, z, fl, l, c, pred;
    {n, z, fl, l, c} = f;
    case (code[3:1])
      3'd0:    pred = z;
      3'd1:    pred = c;
      3'd2:    pred = l;
      3'd3:    pred = n;
      3'd4:    pred = fl;
      3'd5:    pred = !l && !z;
      3'd6:    pred = !n && !z;
      default: pred = 1'b1;
    endcase
    return pred ^ code[0];
  endfunction

  // One clock cycle with the currently driven inputs; checks cond_ready
  // before the edge and psr/taken_valid/taken after it, for both instances.
  task automatic tick();
    logic [4:0] nxt;
    logic [4:0] view;
    logic [1:0] n_tv;
    logic [1:0] n_tk;
    logic       rdy;
    logic       act_rdy;
    #1;
    nxt = bus.psr_ld ? bus.psr_ld_data : m_psr;
    if (!bus.psr_ld)
      for (int b = 0; b < 5; b++)
        if (bus.flag_we[b]) nxt[b] = bus.PSRwrite[b];
    n_tv = m_tv;
    n_tk = m_tk;
    for (int f = 0; f < 2; f++) begin
      rdy = !m_tv[f] || bus.taken_ready;
      if (m_synced) begin
        act_rdy = (f == 1) ? bus.cond_ready : bus0.cond_ready;
        check((f == 1) ? "model cond_ready fwd" : "model cond_ready nofwd", 32'(act_rdy), 32'(rdy));
      end
      view = (f == 1) ? nxt : m_psr;
      if (bus.cond_valid && rdy) begin
        n_tv[f] = 1'b1;
        n_tk[f] = model_cond(bus.cond_code, view);
      end else if (bus.taken_ready) begin
        n_tv[f] = 1'b0;
      end
    end
    if (!reset) begin
      nxt  = 5'b00000;
      n_tv = 2'b00;
      n_tk = 2'b00;
    end
    @(posedge clk);
    #1;
    if (!reset) m_synced = 1'b1;
    m_psr = nxt;
    m_tv  = n_tv;
    m_tk  = n_tk;
    if (m_synced) begin
      check("model psr fwd",           32'(bus.psr),          32'(m_psr));
      check("model psr nofwd",         32'(bus0.psr),         32'(m_psr));
      check("model taken_valid fwd",   32'(bus.taken_valid),  32'(m_tv[1]));
      check("model taken_valid nofwd", 32'(bus0.taken_valid), 32'(m_tv[0]));
      check("model taken fwd",         32'(bus.taken),        32'(m_tk[1]));
      check("model taken nofwd",       32'(bus0.taken),       32'(m_tk[0]));
    end
  endtask

  task automatic idle_inputs();
    bus.PSRwrite    = 5'b0;
    bus.flag_we     = 5'b0;
    bus.psr_ld      = 1'b0;
    bus.psr_ld_data = 5'b0;
    bus.cond_valid  = 1'b0;
    bus.cond_code   = 4'h0;
    bus.taken_ready = 1'b1;
  endtask

  // Condition sweep vectors: PSR value and hand-derived taken bit per code
  // (bit i of mask = expected taken for cond_code i).
  typedef struct {
    logic [4:0]  psr_val;
    logic [15:0] mask;
  } sweep_t;

  sweep_t sweep[6];

  initial begin
    sweep[0] = '{5'b00000, 16'h56AA};
    sweep[1] = '{5'b01000, 16'h6AA9};
    sweep[2] = '{5'b00010, 16'h5A9A};
    sweep[3] = '{5'b10000, 16'h666A};
    sweep[4] = '{5'b00100, 16'h55AA};
    sweep[5] = '{5'b00001, 16'h56A6};

    idle_inputs();
    m_psr = 5'b0;
    m_tv  = 2'b0;
    m_tk  = 2'b0;

    // Reset held two cycles with a request pending.
    reset           = 1'b0;
    bus.cond_valid  = 1'b1;
    bus.cond_code   = 4'hE;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset psr",         32'(bus.psr),          32'h00);
      check("reset taken_valid", 32'(bus.taken_valid),  32'h0);
      check("reset taken_valid nofwd", 32'(bus0.taken_valid), 32'h0);
    end
    reset          = 1'b1;
    bus.cond_valid = 1'b0;
    #1;
    check("cond_ready after reset", 32'(bus.cond_ready), 32'h1);

    // Masked flag update, then full load overriding flag_we.
    bus.flag_we  = 5'b01010;
    bus.PSRwrite = 5'b11111;
    tick();
    check("masked update psr", 32'(bus.psr), 32'h0A);
    bus.psr_ld      = 1'b1;
    bus.psr_ld_data = 5'b10001;
    bus.flag_we     = 5'b11111;
    bus.PSRwrite    = 5'b00000;
    tick();
    check("psr_ld overrides flag_we", 32'(bus.psr), 32'h11);
    idle_inputs();

    // Full condition sweep, one decision per cycle.
    for (int s = 0; s < 6; s++) begin
      bus.psr_ld      = 1'b1;
      bus.psr_ld_data = sweep[s].psr_val;
      tick();
      bus.psr_ld = 1'b0;
      check("sweep psr load", 32'(bus.psr), 32'(sweep[s].psr_val));
      for (int c = 0; c < 16; c++) begin
        logic [15:0] m;
        bus.cond_valid = 1'b1;
        bus.cond_code  = 4'(c);
        tick();
        m = sweep[s].mask;
        check($sformatf("sweep psr=%05b code=%0d taken", sweep[s].psr_val, c),
              32'(bus.taken), 32'(m[c]));
        check($sformatf("sweep psr=%05b code=%0d taken nofwd", sweep[s].psr_val, c),
              32'(bus0.taken), 32'(m[c]));
        check("sweep taken_valid", 32'(bus.taken_valid), 32'h1);
      end
      bus.cond_valid = 1'b0;
      tick();
      check("sweep drained", 32'(bus.taken_valid), 32'h0);
    end

    // Forwarding: Z set in the same cycle as an EQ request.
    bus.psr_ld      = 1'b1;
    bus.psr_ld_data = 5'b00000;
    tick();
    bus.psr_ld     = 1'b0;
    bus.flag_we    = 5'b01000;
    bus.PSRwrite   = 5'b01000;
    bus.cond_valid = 1'b1;
    bus.cond_code  = 4'h0;
    tick();
    check("forward EQ sees new Z", 32'(bus.taken),  32'h1);
    check("no-forward EQ sees old Z", 32'(bus0.taken), 32'h0);
    idle_inputs();

    // Backpressure: EQ=1 decision held while Z is cleared underneath it.
    bus.taken_ready = 1'b0;
    bus.cond_valid  = 1'b1;
    bus.cond_code   = 4'h0;
    tick();
    check("bp first decision", 32'(bus.taken), 32'h1);
    bus.psr_ld      = 1'b1;
    bus.psr_ld_data = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp cond_ready low", 32'(bus.cond_ready), 32'h0);
      tick();
      bus.psr_ld = 1'b0;
      check("bp taken held",       32'(bus.taken),       32'h1);
      check("bp taken_valid held", 32'(bus.taken_valid), 32'h1);
    end
    bus.taken_ready = 1'b1;
    bus.cond_code   = 4'h1;
    #1;
    check("bp drain+accept ready", 32'(bus.cond_ready), 32'h1);
    tick();
    check("bp NE decision", 32'(bus.taken), 32'h1);
    check("bp NE valid",    32'(bus.taken_valid), 32'h1);
    idle_inputs();

    // Reset in the middle of a stalled handshake.
    bus.psr_ld      = 1'b1;
    bus.psr_ld_data = 5'b10101;
    bus.taken_ready = 1'b0;
    bus.cond_valid  = 1'b1;
    bus.cond_code   = 4'hE;
    tick();
    bus.psr_ld = 1'b0;
    check("pre-reset taken_valid", 32'(bus.taken_valid), 32'h1);
    reset = 1'b0;
    tick();
    check("mid reset taken_valid", 32'(bus.taken_valid), 32'h0);
    check("mid reset psr",         32'(bus.psr),         32'h00);
    reset = 1'b1;
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 39) != 0);
      bus.PSRwrite    = 5'($urandom);
      bus.flag_we     = 5'($urandom);
      bus.psr_ld      = ($urandom_range(0, 7) == 0);
      bus.psr_ld_data = 5'($urandom);
      bus.cond_valid  = ($urandom_range(0, 3) != 0);
      bus.cond_code   = 4'($urandom);
      bus.taken_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
